instr_decode_stage: RTL and testbench

RV32I decode stage sitting directly upstream of the immediate generator. It accepts fetched instruction words over a valid/ready handshake and buffers them in a 2-entry skid FIFO. It decodes each word into the immediate-format code, opcode class and register/control fields that the immediate generator and execute stage consume, and inserts a one-cycle bubble on load-use hazards.

---
 rtl/instr_decode_stage.sv | 192 +++++++++++++++++++
 tb/tb_instr_decode_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode_stage.sv
// RV32I decode stage: 2-entry skid FIFO with bypass feeding a registered decode
// output, with a one-cycle bubble on load-use hazards against the output register.
module instr_decode_stage #(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_ins,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_ins,
  output logic [PC_W-1:0] out_pc,
  output logic [2:0]      out_imm_type,
  output logic [1:0]      out_opcode,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_reg_we,
  output logic            out_mem_rd,
  output logic            out_mem_wr,
  output logic            out_branch,
  output logic            out_jump,
  output logic            out_illegal
);
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  logic [31:0]     r_fifo_ins [2];
  logic [PC_W-1:0] r_fifo_pc  [2];
  logic            r_rd_ptr, r_wr_ptr;
  logic [1:0]      r_count;
  logic [1:0]      w_count_next;

  logic            r_out_valid, r_out_reg_we, r_out_mem_rd, r_out_mem_wr;
  logic            r_out_branch, r_out_jump, r_out_illegal;
  logic [31:0]     r_out_ins;
  logic [PC_W-1:0] r_out_pc;
  logic [2:0]      r_out_imm_type;
  logic [1:0]      r_out_opcode;
  logic [4:0]      r_out_rs1, r_out_rs2, r_out_rd;

  logic            w_xfer, w_adv, w_src_valid, w_hazard, w_issue, w_push, w_pop;
  logic [31:0]     w_src_ins;
  logic [PC_W-1:0] w_src_pc;
  logic [2:0]      w_imm_type;
  logic [1:0]      w_class;
  logic            w_we, w_mrd, w_mwr, w_br, w_jmp, w_use1, w_use2, w_ill;

  assign in_ready    = (r_count != 2'd2);
  assign w_xfer      = in_valid & in_ready;
  assign w_adv       = !r_out_valid | out_ready;
  assign w_src_valid = (r_count != 2'd0) | w_xfer;
  assign w_src_ins   = (r_count != 2'd0) ? r_fifo_ins[r_rd_ptr] : in_ins;
  assign w_src_pc    = (r_count != 2'd0) ? r_fifo_pc[r_rd_ptr]  : in_pc;

  always_comb begin
    w_imm_type = 3'b111;
    w_class    = 2'b11;
    w_we       = 1'b0;
    w_mrd      = 1'b0;
    w_mwr      = 1'b0;
    w_br       = 1'b0;
    w_jmp      = 1'b0;
    w_use1     = 1'b0;
    w_use2     = 1'b0;
    w_ill      = 1'b0;
    if (w_src_ins[1:0] != 2'b11) begin
      w_ill = 1'b1;
    end else begin
      case (w_src_ins[6:2])
        OPC_LOAD:   begin w_imm_type = 3'b000; w_class = 2'b01; w_we = 1'b1; w_mrd = 1'b1; w_use1 = 1'b1; end
        OPC_OPIMM:  begin w_imm_type = 3'b000; w_class = 2'b00; w_we = 1'b1; w_use1 = 1'b1; end
        OPC_AUIPC:  begin w_imm_type = 3'b001; w_class = 2'b00; w_we = 1'b1; end
        OPC_STORE:  begin w_imm_type = 3'b110; w_class = 2'b01; w_mwr = 1'b1; w_use1 = 1'b1; w_use2 = 1'b1; end
        OPC_OP:     begin w_imm_type = 3'b111; w_class = 2'b00; w_we = 1'b1; w_use1 = 1'b1; w_use2 = 1'b1; end
        OPC_LUI:    begin w_imm_type = 3'b001; w_class = 2'b00; w_we = 1'b1; end
        OPC_BRANCH: begin w_imm_type = 3'b010; w_class = 2'b10; w_br = 1'b1; w_use1 = 1'b1; w_use2 = 1'b1; end
        OPC_JALR:   begin w_imm_type = 3'b000; w_class = 2'b11; w_we = 1'b1; w_jmp = 1'b1; w_use1 = 1'b1; end
        OPC_JAL:    begin w_imm_type = 3'b011; w_class = 2'b11; w_we = 1'b1; w_jmp = 1'b1; end
        OPC_SYSTEM: begin w_imm_type = 3'b111; w_class = 2'b11; end
        default:    w_ill = 1'b1;
      endcase
    end
    if (w_src_ins[11:7] == 5'd0) w_we = 1'b0;
  end

  // Only loads sitting in the output register can stall the word behind them.
  assign w_hazard = r_out_valid & r_out_mem_rd & (r_out_rd != 5'd0) &
                    ((w_use1 & (w_src_ins[19:15] == r_out_rd)) |
                     (w_use2 & (w_src_ins[24:20] == r_out_rd)));
  assign w_issue  = w_adv & w_src_valid & !w_hazard & !flush;
  assign w_pop    = w_issue & (r_count != 2'd0);
  // A bypassed word that issues skips the FIFO; a stalled or hazarded one is kept.
  assign w_push   = w_xfer & !flush & !(w_issue & (r_count == 2'd0));

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 2'd1;
      2'b01:   w_count_next = r_count - 2'd1;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_ins[r_wr_ptr] <= in_ins;
      r_fifo_pc[r_wr_ptr]  <= in_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= 2'd0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
    end else if (flush) begin
      r_count  <= 2'd0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
    end else begin
      r_count <= w_count_next;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid    <= 1'b0;
      r_out_ins      <= '0;
      r_out_pc       <= '0;
      r_out_imm_type <= 3'b000;
      r_out_opcode   <= 2'b00;
      r_out_rs1      <= 5'd0;
      r_out_rs2      <= 5'd0;
      r_out_rd       <= 5'd0;
      r_out_reg_we   <= 1'b0;
      r_out_mem_rd   <= 1'b0;
      r_out_mem_wr   <= 1'b0;
      r_out_branch   <= 1'b0;
      r_out_jump     <= 1'b0;
      r_out_illegal  <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= w_issue;
      if (w_issue) begin
        r_out_ins      <= w_src_ins;
        r_out_pc       <= w_src_pc;
        r_out_imm_type <= w_imm_type;
        r_out_opcode   <= w_class;
        r_out_rs1      <= w_src_ins[19:15];
        r_out_rs2      <= w_src_ins[24:20];
        r_out_rd       <= w_src_ins[11:7];
        r_out_reg_we   <= w_we;
        r_out_mem_rd   <= w_mrd;
        r_out_mem_wr   <= w_mwr;
        r_out_branch   <= w_br;
        r_out_jump     <= w_jmp;
        r_out_illegal  <= w_ill;
      end
    end
  end

  assign out_valid    = r_out_valid;
  assign out_ins      = r_out_ins;
  assign out_pc       = r_out_pc;
  assign out_imm_type = r_out_imm_type;
  assign out_opcode   = r_out_opcode;
  assign out_rs1      = r_out_rs1;
  assign out_rs2      = r_out_rs2;
  assign out_rd       = r_out_rd;
  assign out_reg_we   = r_out_reg_we;
  assign out_mem_rd   = r_out_mem_rd;
  assign out_mem_wr   = r_out_mem_wr;
  assign out_branch   = r_out_branch;
  assign out_jump     = r_out_jump;
  assign out_illegal  = r_out_illegal;
endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage: decode fields, load-use bubble,
// backpressure, flush and mid-stream reset, with hand-computed expectations.
module tb_instr_decode_stage;
  localparam int PC_W = 32;

  logic            clk = 1'b0;
  logic            rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0]     in_ins, out_ins;
  logic [PC_W-1:0] in_pc, out_pc;
  logic [2:0]      out_imm_type;
  logic [1:0]      out_opcode;
  logic [4:0]      out_rs1, out_rs2, out_rd;
  logic            out_reg_we, out_mem_rd, out_mem_wr, out_branch, out_jump, out_illegal;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  instr_decode_stage #(.PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ins(in_ins), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_ins(out_ins), .out_pc(out_pc),
    .out_imm_type(out_imm_type), .out_opcode(out_opcode), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_rd(out_rd), .out_reg_we(out_reg_we),
    .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr), .out_branch(out_branch),
    .out_jump(out_jump), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    $display("[TB] cyc %0d in_rdy=%0d out_v=%0d ins=%h pc=%h imm=%0d cls=%0d",
             cyc, in_ready, out_valid, out_ins, out_pc, out_imm_type, out_opcode);
  endtask

  task automatic drive(input logic [31:0] ins, input logic [PC_W-1:0] pc);
    in_valid = 1'b1;
    in_ins   = ins;
    in_pc    = pc;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_ins = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_ins", out_ins, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_imm_type", out_imm_type, 0);
    chk("rst_opcode", out_opcode, 0);
    chk("rst_reg_we", out_reg_we, 0);
    chk("rst_illegal", out_illegal, 0);
    rst = 1'b0;

    // addi x1,x2,5
    drive(32'h00510093, 32'h100); step(); in_valid = 1'b0;
    chk("addi_valid", out_valid, 1);
    chk("addi_ins", out_ins, 32'h00510093);
    chk("addi_pc", out_pc, 32'h100);
    chk("addi_imm", out_imm_type, 3'b000);
    chk("addi_cls", out_opcode, 2'b00);
    chk("addi_rs1", out_rs1, 2);
    chk("addi_rd", out_rd, 1);
    chk("addi_we", out_reg_we, 1);
    chk("addi_mrd", out_mem_rd, 0);
    chk("addi_mwr", out_mem_wr, 0);

    // sw x3,8(x2) then nop
    drive(32'h00312423, 32'h104); step();
    chk("sw_imm", out_imm_type, 3'b110);
    chk("sw_cls", out_opcode, 2'b01);
    chk("sw_mwr", out_mem_wr, 1);
    chk("sw_we", out_reg_we, 0);
    chk("sw_rs2", out_rs2, 3);
    chk("sw_rs1", out_rs1, 2);
    drive(32'h00000013, 32'h108); step(); in_valid = 1'b0;
    chk("nop_rd", out_rd, 0);
    chk("nop_we", out_reg_we, 0);
    chk("nop_mwr", out_mem_wr, 0);

    // lw x5,0(x1) then add x6,x5,x7 back-to-back: one bubble
    drive(32'h0000A283, 32'h10C); step();
    chk("lw_valid", out_valid, 1);
    chk("lw_mrd", out_mem_rd, 1);
    chk("lw_rd", out_rd, 5);
    drive(32'h00728333, 32'h110); step(); in_valid = 1'b0;
    chk("hz_bubble", out_valid, 0);
    chk("hz_in_ready", in_ready, 1);
    step();
    chk("hz_add_valid", out_valid, 1);
    chk("hz_add_ins", out_ins, 32'h00728333);
    chk("hz_add_pc", out_pc, 32'h110);
    chk("hz_add_rs1", out_rs1, 5);
    chk("hz_add_rs2", out_rs2, 7);
    chk("hz_add_rd", out_rd, 6);
    step();
    chk("hz_drain", out_valid, 0);

    // lw x5 then addi x6,x4,1: no dependency, no bubble
    drive(32'h0000A283, 32'h114); step();
    drive(32'h00120313, 32'h118); step(); in_valid = 1'b0;
    chk("nohz_valid", out_valid, 1);
    chk("nohz_ins", out_ins, 32'h00120313);

    // jal x1, beq x0,x0, lui x5, illegal words
    drive(32'h000000EF, 32'h11C); step();
    chk("jal_imm", out_imm_type, 3'b011);
    chk("jal_cls", out_opcode, 2'b11);
    chk("jal_jump", out_jump, 1);
    chk("jal_we", out_reg_we, 1);
    drive(32'h00000063, 32'h120); step();
    chk("beq_imm", out_imm_type, 3'b010);
    chk("beq_cls", out_opcode, 2'b10);
    chk("beq_branch", out_branch, 1);
    chk("beq_we", out_reg_we, 0);
    drive(32'h000012B7, 32'h124); step();
    chk("lui_imm", out_imm_type, 3'b001);
    chk("lui_cls", out_opcode, 2'b00);
    chk("lui_we", out_reg_we, 1);
    chk("lui_rd", out_rd, 5);
    drive(32'hFFFFFFFF, 32'h128); step();
    chk("ill_valid", out_valid, 1);
    chk("ill_flag", out_illegal, 1);
    chk("ill_imm", out_imm_type, 3'b111);
    chk("ill_cls", out_opcode, 2'b11);
    chk("ill_flags", {out_reg_we, out_mem_rd, out_mem_wr, out_branch, out_jump}, 0);
    drive(32'h00510090, 32'h12C); step(); in_valid = 1'b0;
    chk("ill2_flag", out_illegal, 1);
    chk("ill2_we", out_reg_we, 0);
    step();
    chk("ill_drain", out_valid, 0);

    // backpressure: 3 absorbed, then in order after release
    out_ready = 1'b0;
    drive(32'h00100093, 32'h200); step();
    chk("bp_in_ready1", in_ready, 1);
    drive(32'h00200113, 32'h204); step();
    chk("bp_in_ready2", in_ready, 1);
    drive(32'h00300193, 32'h208); step();
    chk("bp_full", in_ready, 0);
    chk("bp_head", out_ins, 32'h00100093);
    drive(32'h00400213, 32'h20C); step();
    chk("bp_stable_ins", out_ins, 32'h00100093);
    chk("bp_stable_valid", out_valid, 1);
    chk("bp_still_full", in_ready, 0);
    out_ready = 1'b1; step();
    chk("bp_w2", out_ins, 32'h00200113);
    chk("bp_ready_again", in_ready, 1);
    step(); in_valid = 1'b0;
    chk("bp_w3", out_ins, 32'h00300193);
    step();
    chk("bp_w4", out_ins, 32'h00400213);
    chk("bp_w4_pc", out_pc, 32'h20C);
    chk("bp_w4_valid", out_valid, 1);
    step();
    chk("bp_drain", out_valid, 0);

    // flush with 2 buffered and a concurrent word
    out_ready = 1'b0;
    drive(32'h00500293, 32'h300); step();
    drive(32'h00600313, 32'h304); step();
    drive(32'h00700393, 32'h308); step();
    chk("fl_pre_valid", out_valid, 1);
    chk("fl_pre_full", in_ready, 0);
    drive(32'h00800413, 32'h30C); flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("fl_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fl_quiet", out_valid, 0);
    end

    // asynchronous reset mid-stream
    out_ready = 1'b0;
    drive(32'h00900493, 32'h400); step();
    drive(32'h00A00513, 32'h404); step(); in_valid = 1'b0;
    rst = 1'b1; #1;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_ins", out_ins, 0);
    rst = 1'b0; out_ready = 1'b1;
    step();
    chk("mrst_no_residue", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
